// File: rtl/parking_lot_controller.sv
// N-slot parking controller: self-generated time base, per-slot entry stamps, saturating exit fee.
// Latency 1: commands take effect at the sampling edge; outputs are visible the next cycle.
// No backpressure: enter/exit are single-cycle commands and bad ones are rejected with err/err_code.
// Optional PARK_GRACE_EN: exits with a duration of at most GRACE_TICKS are billed 0.
module parking_lot_controller #(
  parameter int NUM_SLOTS   = 4,
  parameter int SEL_W       = 2,
  parameter int TIME_W      = 10,
  parameter int COST_W      = 10,
  parameter int TICK_DIV    = 50000000,
  parameter int RATE        = 1,
  parameter int MIN_FEE     = 1,
  parameter int GRACE_TICKS = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 car_enter,
  input  logic                 car_exit,
  input  logic [SEL_W-1:0]     slot_sel,
  output logic [NUM_SLOTS-1:0] occupied,
  output logic [SEL_W:0]       free_count,
  output logic                 lot_full,
  output logic [TIME_W-1:0]    timer_count,
  output logic                 bill_valid,
  output logic [SEL_W-1:0]     bill_slot,
  output logic [COST_W-1:0]    bill_cost,
  output logic                 err,
  output logic [1:0]           err_code
);

  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  // Fee arithmetic is done at full width so dur*RATE never truncates before saturation.
  localparam int RAW_W = TIME_W + 32;
  localparam int CNT_W = SEL_W + 1;
  localparam logic [RAW_W-1:0] COST_MAX = RAW_W'({COST_W{1'b1}});

`ifdef PARK_GRACE_EN
  localparam bit GRACE_EN = 1'b1;
`else
  localparam bit GRACE_EN = 1'b0;
`endif

  logic [PRE_W-1:0]     prescaler_q,   prescaler_d;
  logic [TIME_W-1:0]    timer_count_q, timer_count_d;
  logic [NUM_SLOTS-1:0] occupied_q,    occupied_d;
  logic [TIME_W-1:0]    entry_time_q [NUM_SLOTS];
  logic [TIME_W-1:0]    entry_time_d [NUM_SLOTS];
  logic [CNT_W-1:0]     free_count_q,  free_count_d;
  logic                 lot_full_q,    lot_full_d;
  logic                 bill_valid_q,  bill_valid_d;
  logic [SEL_W-1:0]     bill_slot_q,   bill_slot_d;
  logic [COST_W-1:0]    bill_cost_q,   bill_cost_d;
  logic                 err_q,         err_d;
  logic [1:0]           err_code_q,    err_code_d;

  logic                 tick;
  logic                 slot_in_range;
  logic                 slot_occ;
  logic [TIME_W-1:0]    sel_entry;
  logic [TIME_W-1:0]    dur;
  logic [RAW_W-1:0]     raw;
  logic [RAW_W-1:0]     raw_min;
  logic [COST_W-1:0]    fee;

  // Time base: prescaler rolls over every TICK_DIV cycles and advances the wrapping timer.
  always_comb begin
    tick          = (prescaler_q == PRE_W'(TICK_DIV - 1));
    prescaler_d   = tick ? '0 : prescaler_q + 1'b1;
    timer_count_d = timer_count_q + TIME_W'(tick);
  end

  // Decode the selected slot without indexing past NUM_SLOTS when slot_sel is out of range.
  always_comb begin
    slot_in_range = 1'b0;
    slot_occ      = 1'b0;
    sel_entry     = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (slot_sel == SEL_W'(i)) begin
        slot_in_range = 1'b1;
        slot_occ      = occupied_q[i];
        sel_entry     = entry_time_q[i];
      end
    end
  end

  // Fee: modular duration times rate, floored at MIN_FEE, capped at the bill_cost range.
  always_comb begin
    dur     = timer_count_q - sel_entry;
    raw     = RAW_W'(dur) * RAW_W'(RATE);
    raw_min = (raw < RAW_W'(MIN_FEE)) ? RAW_W'(MIN_FEE) : raw;
    fee     = (raw_min > COST_MAX) ? COST_MAX[COST_W-1:0] : raw_min[COST_W-1:0];
    if (GRACE_EN && (RAW_W'(dur) <= RAW_W'(GRACE_TICKS))) begin
      fee = '0;
    end
  end

  // Command handling: range/conflict check first, then occupancy check, then update state.
  always_comb begin
    occupied_d   = occupied_q;
    entry_time_d = entry_time_q;
    free_count_d = free_count_q;
    bill_valid_d = 1'b0;
    bill_slot_d  = bill_slot_q;
    bill_cost_d  = bill_cost_q;
    err_d        = 1'b0;
    err_code_d   = err_code_q;

    if ((car_enter && car_exit) || ((car_enter || car_exit) && !slot_in_range)) begin
      err_d      = 1'b1;
      err_code_d = 2'd3;
    end else if (car_enter) begin
      if (slot_occ || lot_full_q) begin
        err_d      = 1'b1;
        err_code_d = 2'd1;
      end else begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
          if (slot_sel == SEL_W'(i)) begin
            occupied_d[i]   = 1'b1;
            entry_time_d[i] = timer_count_q;
          end
        end
        free_count_d = free_count_q - 1'b1;
      end
    end else if (car_exit) begin
      if (!slot_occ) begin
        err_d      = 1'b1;
        err_code_d = 2'd2;
      end else begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
          if (slot_sel == SEL_W'(i)) begin
            occupied_d[i] = 1'b0;
          end
        end
        free_count_d = free_count_q + 1'b1;
        bill_valid_d = 1'b1;
        bill_slot_d  = slot_sel;
        bill_cost_d  = fee;
      end
    end

    lot_full_d = (free_count_d == '0);
  end

  // State registers with synchronous active-low reset; reset discards all parked cars.
  always_ff @(posedge clk) begin
    if (!reset) begin
      prescaler_q   <= '0;
      timer_count_q <= '0;
      occupied_q    <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        entry_time_q[i] <= '0;
      end
      free_count_q  <= CNT_W'(NUM_SLOTS);
      lot_full_q    <= 1'b0;
      bill_valid_q  <= 1'b0;
      bill_slot_q   <= '0;
      bill_cost_q   <= '0;
      err_q         <= 1'b0;
      err_code_q    <= '0;
    end else begin
      prescaler_q   <= prescaler_d;
      timer_count_q <= timer_count_d;
      occupied_q    <= occupied_d;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        entry_time_q[i] <= entry_time_d[i];
      end
      free_count_q  <= free_count_d;
      lot_full_q    <= lot_full_d;
      bill_valid_q  <= bill_valid_d;
      bill_slot_q   <= bill_slot_d;
      bill_cost_q   <= bill_cost_d;
      err_q         <= err_d;
      err_code_q    <= err_code_d;
    end
  end

  assign occupied    = occupied_q;
  assign free_count  = free_count_q;
  assign lot_full    = lot_full_q;
  assign timer_count = timer_count_q;
  assign bill_valid  = bill_valid_q;
  assign bill_slot   = bill_slot_q;
  assign bill_cost   = bill_cost_q;
  assign err         = err_q;
  assign err_code    = err_code_q;

endmodule

// File: tb/tb_parking_lot_controller.sv
// Directed bench for parking_lot_controller with TICK_DIV=4, RATE=2, MIN_FEE=1, GRACE_TICKS=2.
// Commands are driven just after a rising edge and outputs are checked 1 time unit after the next one.
module tb_parking_lot_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic       car_enter;
  logic       car_exit;
  logic [1:0] slot_sel;
  logic [3:0] occupied;
  logic [2:0] free_count;
  logic       lot_full;
  logic [9:0] timer_count;
  logic       bill_valid;
  logic [1:0] bill_slot;
  logic [9:0] bill_cost;
  logic       err;
  logic [1:0] err_code;

  int checks = 0;
  int errors = 0;
  logic [9:0] t;

  parking_lot_controller #(
    .NUM_SLOTS(4), .SEL_W(2), .TIME_W(10), .COST_W(10),
    .TICK_DIV(4), .RATE(2), .MIN_FEE(1), .GRACE_TICKS(2)
  ) dut (
    .clk(clk), .reset(reset), .car_enter(car_enter), .car_exit(car_exit),
    .slot_sel(slot_sel), .occupied(occupied), .free_count(free_count),
    .lot_full(lot_full), .timer_count(timer_count), .bill_valid(bill_valid),
    .bill_slot(bill_slot), .bill_cost(bill_cost), .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Issue one command at the next rising edge, then drop the inputs 1 unit later.
  task automatic cmd(input logic en, input logic ex, input logic [1:0] s);
    car_enter = en;
    car_exit  = ex;
    slot_sel  = s;
    @(posedge clk);
    #1;
    car_enter = 1'b0;
    car_exit  = 1'b0;
  endtask

  // Wait (bounded) until timer_count shows v; timing out counts as a failure.
  task automatic wait_timer(input logic [9:0] v);
    int n = 0;
    while (timer_count !== v && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (timer_count !== v) chk("timer_wait", 32'(timer_count), 32'(v));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b0;
    car_enter = 1'b0;
    car_exit  = 1'b0;
    slot_sel  = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_occupied",   32'(occupied),    0);
    chk("rst_free_count", 32'(free_count),  4);
    chk("rst_lot_full",   32'(lot_full),    0);
    chk("rst_bill_cost",  32'(bill_cost),   0);
    chk("rst_timer",      32'(timer_count), 0);
    chk("rst_bill_valid", 32'(bill_valid),  0);
    chk("rst_err",        32'(err),         0);
    chk("rst_err_code",   32'(err_code),    0);
    @(negedge clk);
    reset = 1'b1;

    // Basic enter/exit: dur 7 units at RATE 2 -> 14.
    wait_timer(10'd5);
    cmd(1'b1, 1'b0, 2'd2);
    chk("enter_occupied", 32'(occupied),   4'b0100);
    chk("enter_free",     32'(free_count), 3);
    chk("enter_no_bill",  32'(bill_valid), 0);
    wait_timer(10'd12);
    cmd(1'b0, 1'b1, 2'd2);
    chk("exit_bill_valid", 32'(bill_valid), 1);
    chk("exit_bill_slot",  32'(bill_slot),  2);
    chk("exit_bill_cost",  32'(bill_cost),  14);
    chk("exit_occupied",   32'(occupied),   0);
    chk("exit_free",       32'(free_count), 4);
    @(posedge clk);
    #1;
    chk("bill_pulse_drop", 32'(bill_valid), 0);
    chk("bill_cost_hold",  32'(bill_cost),  14);

    // Timer wrap: 1020 -> 3 is 7 units.
    wait_timer(10'd1020);
    cmd(1'b1, 1'b0, 2'd1);
    wait_timer(10'd3);
    cmd(1'b0, 1'b1, 2'd1);
    chk("wrap_bill_slot", 32'(bill_slot), 1);
    chk("wrap_bill_cost", 32'(bill_cost), 14);

    // Same-timer enter/exit: dur 0 -> MIN_FEE.
    wait_timer(10'd6);
    cmd(1'b1, 1'b0, 2'd0);
    cmd(1'b0, 1'b1, 2'd0);
    chk("minfee_timer",     32'(timer_count), 6);
    chk("minfee_bill_cost", 32'(bill_cost),   1);
    chk("minfee_bill_slot", 32'(bill_slot),   0);

    // Saturation: dur 600 at RATE 2 -> 1200, capped to 1023.
    wait_timer(10'd20);
    cmd(1'b1, 1'b0, 2'd3);
    wait_timer(10'd620);
    cmd(1'b0, 1'b1, 2'd3);
    chk("sat_bill_cost", 32'(bill_cost), 1023);

    // Fill the lot, then exercise each error code.
    cmd(1'b1, 1'b0, 2'd0);
    cmd(1'b1, 1'b0, 2'd1);
    cmd(1'b1, 1'b0, 2'd2);
    cmd(1'b1, 1'b0, 2'd3);
    chk("full_occupied", 32'(occupied),   4'b1111);
    chk("full_free",     32'(free_count), 0);
    chk("full_lot_full", 32'(lot_full),   1);
    chk("full_no_err",   32'(err),        0);
    cmd(1'b1, 1'b0, 2'd2);
    chk("e1_err",      32'(err),        1);
    chk("e1_code",     32'(err_code),   1);
    chk("e1_occupied", 32'(occupied),   4'b1111);
    chk("e1_free",     32'(free_count), 0);
    @(posedge clk);
    #1;
    chk("e1_err_drop",  32'(err),      0);
    chk("e1_code_hold", 32'(err_code), 1);
    cmd(1'b0, 1'b1, 2'd1);
    chk("free1_bill_valid", 32'(bill_valid), 1);
    chk("free1_free",       32'(free_count), 1);
    chk("free1_lot_full",   32'(lot_full),   0);
    cmd(1'b0, 1'b1, 2'd1);
    chk("e2_err",        32'(err),        1);
    chk("e2_code",       32'(err_code),   2);
    chk("e2_occupied",   32'(occupied),   4'b1101);
    chk("e2_no_bill",    32'(bill_valid), 0);
    chk("e2_bill_slot",  32'(bill_slot),  1);
    cmd(1'b1, 1'b1, 2'd1);
    chk("e3_err",      32'(err),        1);
    chk("e3_code",     32'(err_code),   3);
    chk("e3_occupied", 32'(occupied),   4'b1101);
    chk("e3_free",     32'(free_count), 1);
    chk("e3_no_bill",  32'(bill_valid), 0);

    // Grace window on slot 1: dur 2 then dur 3.
    t = timer_count + 10'd1;
    wait_timer(t);
    cmd(1'b1, 1'b0, 2'd1);
    wait_timer(t + 10'd2);
    cmd(1'b0, 1'b1, 2'd1);
`ifdef PARK_GRACE_EN
    chk("grace_dur2_cost", 32'(bill_cost), 0);
`else
    chk("grace_dur2_cost", 32'(bill_cost), 4);
`endif
    chk("grace_dur2_valid", 32'(bill_valid), 1);
    t = timer_count + 10'd1;
    wait_timer(t);
    cmd(1'b1, 1'b0, 2'd1);
    wait_timer(t + 10'd3);
    cmd(1'b0, 1'b1, 2'd1);
    chk("grace_dur3_cost", 32'(bill_cost), 6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
